l2_line_mem_responder: RTL and testbench



---
 rtl/lc3b_types.sv | 15 +
 rtl/line_mem_array.sv | 26 ++
 rtl/l2_line_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_l2_line_mem_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types and constants for the L2 line protocol memory side.
package lc3b_types;

  localparam int unsigned LC3B_LINE_BITS = 256;
  localparam int unsigned LINE_OFFSET_W  = 5;

  typedef logic [LC3B_LINE_BITS-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } l2mem_state_t;

endpackage

// File: rtl/line_mem_array.sv
// Line-granular storage: one synchronous write port, one combinational read port, no reset.
module line_mem_array #(
  parameter int unsigned IDX_W     = 11,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     widx_i,
  input  logic [LINE_BITS-1:0] wdata_i,
  input  logic [IDX_W-1:0]     ridx_i,
  output logic [LINE_BITS-1:0] rdata_c
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [LINE_BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_c = mem_q[ridx_i];

endmodule

// File: rtl/l2_line_mem_responder.sv
// Memory-side responder for L2 line requests: fixed-latency mem_resp backed by line storage,
// with abort handling, sticky protocol-error flag and wrapping access counters.
module l2_line_mem_responder
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned LINE_BITS = LC3B_LINE_BITS,
  parameter int unsigned IDX_W     = 11,
  parameter int unsigned LATENCY   = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [ADDR_W-1:0]    mem_address,
  input  logic [LINE_BITS-1:0] mem_wdata,
  output logic                 mem_resp,
  output logic [LINE_BITS-1:0] mem_rdata,
  output logic                 proto_err,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);

  localparam int unsigned CNT_W = 8;

  l2mem_state_t         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 op_wr_q, op_wr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic                 proto_q, proto_d;
  logic                 resp_q;
  logic [LINE_BITS-1:0] rdata_q;
  logic [15:0]          rd_cnt_q, wr_cnt_q;

  logic                 req_c;
  logic [IDX_W-1:0]     req_idx_c;
  logic                 we_c;
  logic                 cap_c;
  logic [IDX_W-1:0]     cidx_c;
  logic [LINE_BITS-1:0] cwdata_c;
  logic [LINE_BITS-1:0] arr_rdata_c;
  logic                 unused_c;

  assign req_c     = mem_read | mem_write;
  assign req_idx_c = mem_address[IDX_W+LINE_OFFSET_W-1:LINE_OFFSET_W];
  assign unused_c  = ^mem_address[LINE_OFFSET_W-1:0];

  // Next-state, latch and commit-strobe logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    proto_d  = proto_q;
    we_c     = 1'b0;
    cap_c    = 1'b0;
    cidx_c   = idx_q;
    cwdata_c = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          op_wr_d = mem_write;
          idx_d   = req_idx_c;
          wdata_d = mem_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (mem_read && mem_write) begin
            proto_d = 1'b1;
          end
          if (LATENCY > 1) begin
            state_d = BUSY;
          end else begin
            // Single-cycle latency commits straight from the live request
            state_d  = RESP;
            we_c     = mem_write;
            cap_c    = ~mem_write;
            cidx_c   = req_idx_c;
            cwdata_c = mem_wdata;
          end
        end
      end
      BUSY: begin
        if (!req_c) begin
          state_d = IDLE;
        end else begin
          if ((mem_write != op_wr_q) || (req_idx_c != idx_q)) begin
            proto_d = 1'b1;
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d = RESP;
            we_c    = op_wr_q;
            cap_c   = ~op_wr_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  line_mem_array #(
    .IDX_W     (IDX_W),
    .LINE_BITS (LINE_BITS)
  ) u_array (
    .clk     (clk),
    .we_i    (we_c),
    .widx_i  (cidx_c),
    .wdata_i (cwdata_c),
    .ridx_i  (cidx_c),
    .rdata_c (arr_rdata_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_wr_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      proto_q  <= 1'b0;
      resp_q   <= 1'b0;
      rdata_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      proto_q <= proto_d;
      resp_q  <= (state_d == RESP);
      if (cap_c) begin
        rdata_q <= arr_rdata_c;
      end
      // Access is counted as it leaves RESP
      if (state_q == RESP) begin
        if (op_wr_q) begin
          wr_cnt_q <= wr_cnt_q + 16'd1;
        end else begin
          rd_cnt_q <= rd_cnt_q + 16'd1;
        end
      end
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;
  assign proto_err = proto_q;
  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_l2_line_mem_responder.sv
// Directed bench for l2_line_mem_responder: LATENCY=10 instance plus a LATENCY=1 instance.
module tb_l2_line_mem_responder;

  logic         clk;
  logic         rst_n;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [255:0] mem_wdata;
  logic         mem_resp;
  logic [255:0] mem_rdata;
  logic         proto_err;
  logic [15:0]  rd_count, wr_count;

  logic         m1_read, m1_write;
  logic [15:0]  m1_address;
  logic [255:0] m1_wdata;
  logic         m1_resp;
  logic [255:0] m1_rdata;
  logic         m1_proto;
  logic [15:0]  m1_rd_count, m1_wr_count;

  int n_checks;
  int n_errs;

  l2_line_mem_responder #(.LATENCY(10)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata),
    .proto_err   (proto_err),
    .rd_count    (rd_count),
    .wr_count    (wr_count)
  );

  l2_line_mem_responder #(.LATENCY(1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read    (m1_read),
    .mem_write   (m1_write),
    .mem_address (m1_address),
    .mem_wdata   (m1_wdata),
    .mem_resp    (m1_resp),
    .mem_rdata   (m1_rdata),
    .proto_err   (m1_proto),
    .rd_count    (m1_rd_count),
    .wr_count    (m1_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a request on the LATENCY=10 port and count negedges until mem_resp; request is left asserted.
  task automatic req0(input logic wr, input logic rd, input logic [15:0] a,
                      input logic [255:0] d, output int lat);
    bit seen;
    @(negedge clk);
    mem_write = wr; mem_read = rd; mem_address = a; mem_wdata = d;
    lat = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (mem_resp) seen = 1;
    end
    if (!seen) lat = 999;
  endtask

  task automatic drop0();
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic watch_idle(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mem_resp) hits++;
    end
  endtask

  localparam logic [255:0] P_A5 = {32{8'hA5}};
  localparam logic [255:0] P3   = {8{32'hDEADBEEF}};
  localparam logic [255:0] P5A  = {16{16'h5A5A}};
  localparam logic [255:0] P5B  = {8{32'h0BADF00D}};
  localparam logic [255:0] P5C  = {8{32'hC0FFEE11}};
  localparam logic [255:0] P6   = {4{64'h0123456789ABCDEF}};

  initial begin
    int lat;
    int hits;
    n_checks = 0;
    n_errs   = 0;
    rst_n = 1'b0;
    mem_read = 0; mem_write = 0; mem_address = '0; mem_wdata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_resp", 256'(mem_resp), 256'(0));
    chk("reset_rdata", mem_rdata, 256'(0));
    chk("reset_counts", 256'({rd_count, wr_count, 15'd0, proto_err}), 256'(0));

    // 1: reset mid-BUSY drops the access
    mem_read = 1; mem_address = 16'h0040;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 256'({mem_resp, proto_err, rd_count, wr_count}), 256'(0));
    chk("rst_mid_rdata", mem_rdata, 256'(0));
    drop0();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch_idle(15, hits);
    chk("rst_mid_no_resp", 256'(hits), 256'(0));
    chk("rst_mid_rd_count", 256'(rd_count), 256'(0));

    // 2: basic write then read with full latency
    req0(1, 0, 16'h1020, P_A5, lat);
    chk("wr_latency", 256'(lat), 256'(10));
    drop0();
    @(negedge clk);
    chk("wr_resp_width", 256'(mem_resp), 256'(0));
    chk("wr_count_1", 256'(wr_count), 256'(1));
    req0(0, 1, 16'h1020, '0, lat);
    chk("rd_latency", 256'(lat), 256'(10));
    chk("rd_data_a5", mem_rdata, P_A5);
    drop0();
    @(negedge clk);
    chk("rd_resp_width", 256'(mem_resp), 256'(0));
    chk("rd_count_1", 256'(rd_count), 256'(1));

    // 3: back-to-back write then read, offset ignored
    req0(1, 0, 16'h2000, P3, lat);
    chk("b2b_wr_latency", 256'(lat), 256'(10));
    mem_write = 0; mem_read = 1; mem_address = 16'h201F;
    lat = 0; hits = 0;
    for (int i = 0; i < 40 && hits == 0; i++) begin
      @(negedge clk);
      lat++;
      if (mem_resp) hits = 1;
    end
    chk("b2b_resp_spacing", 256'(lat), 256'(11));
    chk("b2b_rd_data", mem_rdata, P3);
    drop0();
    @(negedge clk);
    chk("b2b_counts", 256'({rd_count, wr_count}), 256'({16'd2, 16'd2}));

    // 4: abort mid-BUSY, then a normal read
    @(negedge clk);
    mem_read = 1; mem_address = 16'h0300;
    repeat (5) @(negedge clk);
    drop0();
    watch_idle(15, hits);
    chk("abort_no_resp", 256'(hits), 256'(0));
    chk("abort_counts", 256'({rd_count, wr_count}), 256'({16'd2, 16'd2}));
    chk("abort_rdata_held", mem_rdata, P3);
    req0(0, 1, 16'h1020, '0, lat);
    chk("post_abort_latency", 256'(lat), 256'(10));
    chk("post_abort_data", mem_rdata, P_A5);
    drop0();
    @(negedge clk);
    chk("post_abort_rd_count", 256'(rd_count), 256'(3));
    chk("no_err_yet", 256'(proto_err), 256'(0));

    // 5a: both requests high -> error, treated as write
    req0(1, 1, 16'h0500, P5A, lat);
    chk("both_latency", 256'(lat), 256'(10));
    chk("both_proto_err", 256'(proto_err), 256'(1));
    drop0();
    req0(0, 1, 16'h0500, '0, lat);
    chk("both_committed", mem_rdata, P5A);
    drop0();
    @(negedge clk);
    chk("both_counts", 256'({rd_count, wr_count}), 256'({16'd4, 16'd3}));

    // Reset clears flag and counts but not storage
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_clears_err", 256'({proto_err, rd_count, wr_count}), 256'(0));
    req0(0, 1, 16'h1020, '0, lat);
    chk("storage_survives_reset", mem_rdata, P_A5);
    drop0();

    // 5b: address change mid-BUSY -> error, latched line commits
    req0(1, 0, 16'h0420, P5C, lat);
    drop0();
    @(negedge clk);
    mem_write = 1; mem_address = 16'h0400; mem_wdata = P5B;
    lat = 0;
    repeat (3) begin @(negedge clk); lat++; end
    mem_address = 16'h0420;
    hits = 0;
    for (int i = 0; i < 40 && hits == 0; i++) begin
      @(negedge clk);
      lat++;
      if (mem_resp) hits = 1;
    end
    chk("addr_chg_latency", 256'(lat), 256'(10));
    chk("addr_chg_proto_err", 256'(proto_err), 256'(1));
    drop0();
    req0(0, 1, 16'h0400, '0, lat);
    chk("addr_chg_commit_0400", mem_rdata, P5B);
    drop0();
    req0(0, 1, 16'h0420, '0, lat);
    chk("addr_chg_0420_intact", mem_rdata, P5C);
    drop0();
    repeat (5) @(negedge clk);
    chk("proto_err_sticky", 256'(proto_err), 256'(1));
    chk("counts_after_5b", 256'({rd_count, wr_count}), 256'({16'd3, 16'd2}));

    // 6: LATENCY=1 instance and counter wrap
    @(negedge clk);
    m1_write = 1; m1_address = 16'h0060; m1_wdata = P6;
    @(negedge clk);
    chk("l1_wr_resp", 256'(m1_resp), 256'(1));
    m1_write = 0;
    @(negedge clk);
    chk("l1_wr_resp_width", 256'(m1_resp), 256'(0));
    chk("l1_wr_count", 256'(m1_wr_count), 256'(1));
    m1_read = 1; m1_address = 16'h007F;
    @(negedge clk);
    chk("l1_rd_resp", 256'(m1_resp), 256'(1));
    chk("l1_rd_data", m1_rdata, P6);
    m1_read = 0;
    @(negedge clk);
    chk("l1_rd_count", 256'(m1_rd_count), 256'(1));
    force u_dut1.rd_cnt_q = 16'hFFFF;
    @(negedge clk);
    release u_dut1.rd_cnt_q;
    @(negedge clk);
    chk("l1_preload", 256'(m1_rd_count), 256'(16'hFFFF));
    m1_read = 1; m1_address = 16'h0060;
    @(negedge clk);
    chk("l1_wrap_resp", 256'(m1_resp), 256'(1));
    m1_read = 0;
    @(negedge clk);
    chk("l1_rd_wrap", 256'(m1_rd_count), 256'(0));
    chk("l1_no_err", 256'(m1_proto), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
